uart_frame_receiver: RTL and testbench

Receiving end of the camera UART frame link: deserializes 8N1 bytes from i_RX and writes each byte sequentially into a frame-buffer RAM write port (address, data, write-enable). Frames are delimited by the frame-indicator line driven by the sender; a falling edge arms capture at address 0. The block counts bytes to a full frame, flags completion, and aborts on timeout, stop-bit error or indicator misuse. Used on the host/board-test side and for FPGA loopback checks of the camera transmitter.

---
 rtl/uart_frame_receiver_pkg.sv | 25 ++
 rtl/uart_frame_receiver_if.sv | 21 ++
 rtl/uart_rx_byte.sv | 94 +++++++++
 rtl/uart_frame_receiver.sv | 136 +++++++++++++
 tb/tb_uart_frame_receiver.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_receiver_pkg.sv
// Shared constants and state encodings for the camera UART frame link.
// Defaults match the camera transmitter: 115200 baud at 125 MHz, one
// 12672-byte frame per indicator cycle.
package uart_frame_receiver_pkg;

    localparam int DEF_CLKS_PER_BIT     = 1085;
    localparam int DEF_BYTES_PER_FRAME  = 12672;
    localparam int DEF_GAP_TIMEOUT_CLKS = 500000;

    // Frame-level sequencing: waiting for an arm, armed, or mid-frame.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        RECEIVING = 2'd2
    } frame_state_t;

    // Byte-level 8N1 deserializer states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Frame-buffer RAM write port. The receiver drives it (master); the RAM
// or any observer samples it (slave).
interface uart_frame_receiver_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] o_Write_Adress;
    logic [7:0]        o_RAM_Data;
    logic              o_Enable_Write;

    modport master (
        output o_Write_Adress,
        output o_RAM_Data,
        output o_Enable_Write
    );

    modport slave (
        input o_Write_Adress,
        input o_RAM_Data,
        input o_Enable_Write
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserializer: synchronizes the serial line, qualifies the start
// bit at its midpoint, samples 8 data bits LSB first at bit centres and
// reports either a good byte or a bad stop bit as a one-cycle pulse.
module uart_rx_byte
    import uart_frame_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       Clk,
    input  logic       i_Rst_n,
    input  logic       i_RX,
    output logic       byte_valid,
    output logic       stop_err,
    output logic [7:0] rx_data
);

    localparam int            TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] BIT_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    rx_sync;
    logic          rx_s;
    rx_state_t     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign rx_s    = rx_sync[1];
    assign rx_data = shreg;

    // Two-flop synchronizer on the asynchronous serial line.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            // NOTE: preset to the idle level so leaving reset never fakes a start bit.
            rx_sync <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rx_sync <= {rx_sync[0], i_RX};
        end
    end

    // Bit-timing state machine; byte_valid/stop_err are registered pulses.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= RX_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    // A low that has gone away by mid-bit is treated as a glitch.
                    if (timer == BIT_HALF) begin
                        timer <= '0;
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer      <= '0;
                        byte_valid <= rx_s;
                        stop_err   <= ~rx_s;
                        state      <= RX_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_receiver.sv
// Camera UART frame receiver: stores each received byte sequentially into
// a frame-buffer RAM, framed by the sender's indicator line. Completion is
// flagged at BYTES_PER_FRAME; timeouts, bad stop bits and indicator misuse
// abort the frame. The RAM lives outside, so an abort or reset leaves any
// partial frame contents in place.
module uart_frame_receiver
    import uart_frame_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT     = DEF_CLKS_PER_BIT,
    parameter int BYTES_PER_FRAME  = DEF_BYTES_PER_FRAME,
    parameter int ADDR_W           = 15,
    parameter int GAP_TIMEOUT_CLKS = DEF_GAP_TIMEOUT_CLKS
) (
    input  logic                  Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_RX,
    input  logic                  i_Frame_Indicator,
    uart_frame_receiver_if.master ram,
    output logic [ADDR_W:0]       o_Byte_Count,
    output logic                  o_Busy,
    output logic                  o_Frame_Done,
    output logic                  o_Frame_Error
);

    localparam int                GW            = $clog2(GAP_TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0]     GAP_LAST      = GW'(GAP_TIMEOUT_CLKS);
    localparam logic [ADDR_W:0]   FRAME_LAST_M1 = (ADDR_W + 1)'(BYTES_PER_FRAME - 1);

    logic              rx_byte_valid;
    logic              rx_stop_err;
    logic [7:0]        rx_data;
    logic [1:0]        ind_sync;
    logic              ind_prev;
    logic              ind_fall;
    logic              ind_rise;
    frame_state_t      state;
    logic [ADDR_W-1:0] wr_addr;
    logic [GW-1:0]     gap_cnt;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .Clk        (Clk),
        .i_Rst_n    (i_Rst_n),
        .i_RX       (i_RX),
        .byte_valid (rx_byte_valid),
        .stop_err   (rx_stop_err),
        .rx_data    (rx_data)
    );

    assign ind_fall = ind_prev & ~ind_sync[1];
    assign ind_rise = ~ind_prev & ind_sync[1];

    // Synchronize the frame indicator and keep one delayed copy for edge detection.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ind_sync <= 2'b11;
            ind_prev <= 1'b1;
        end else begin
            ind_sync <= {ind_sync[0], i_Frame_Indicator};
            ind_prev <= ind_sync[1];
        end
    end

    // Frame sequencing, counters and registered RAM write port.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state              <= IDLE;
            wr_addr            <= '0;
            gap_cnt            <= '0;
            o_Byte_Count       <= '0;
            o_Busy             <= 1'b0;
            o_Frame_Done       <= 1'b0;
            o_Frame_Error      <= 1'b0;
            ram.o_Enable_Write <= 1'b0;
            ram.o_Write_Adress <= '0;
            ram.o_RAM_Data     <= '0;
        end else begin
            ram.o_Enable_Write <= 1'b0;
            o_Frame_Done       <= 1'b0;
            o_Frame_Error      <= 1'b0;
            case (state)
                IDLE: begin
                    // Bytes arriving here are dropped; only an arm matters.
                    if (ind_fall) begin
                        state        <= ARMED;
                        o_Busy       <= 1'b1;
                        wr_addr      <= '0;
                        o_Byte_Count <= '0;
                        gap_cnt      <= '0;
                    end
                end
                ARMED, RECEIVING: begin
                    if (ind_fall) begin
                        // Sender restarted: abandon this frame and re-arm at 0.
                        o_Frame_Error <= 1'b1;
                        state         <= ARMED;
                        wr_addr       <= '0;
                        o_Byte_Count  <= '0;
                        gap_cnt       <= '0;
                    end else if (ind_rise || rx_stop_err) begin
                        o_Frame_Error <= 1'b1;
                        o_Busy        <= 1'b0;
                        state         <= IDLE;
                    end else if (rx_byte_valid) begin
                        // A byte beats a coincident timeout.
                        ram.o_Enable_Write <= 1'b1;
                        ram.o_Write_Adress <= wr_addr;
                        ram.o_RAM_Data     <= rx_data;
                        wr_addr            <= wr_addr + 1'b1;
                        o_Byte_Count       <= o_Byte_Count + 1'b1;
                        gap_cnt            <= '0;
                        if (o_Byte_Count == FRAME_LAST_M1) begin
                            o_Frame_Done <= 1'b1;
                            o_Busy       <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            state <= RECEIVING;
                        end
                    end else if (gap_cnt == GAP_LAST) begin
                        o_Frame_Error <= 1'b1;
                        o_Busy        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver with a short bit time and a 4-byte frame.
// Expected RAM writes come from the bytes the bench itself serializes.
module tb_uart_frame_receiver;

    localparam int CPB = 8;
    localparam int BPF = 4;
    localparam int AW  = 3;
    localparam int GAP = 200;

    logic          Clk = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_RX = 1'b1;
    logic          i_Frame_Indicator = 1'b1;
    logic [AW:0]   byte_count;
    logic          busy;
    logic          frame_done;
    logic          frame_error;

    uart_frame_receiver_if #(.ADDR_W(AW)) ram_if ();

    uart_frame_receiver #(
        .CLKS_PER_BIT     (CPB),
        .BYTES_PER_FRAME  (BPF),
        .ADDR_W           (AW),
        .GAP_TIMEOUT_CLKS (GAP)
    ) dut (
        .Clk               (Clk),
        .i_Rst_n           (i_Rst_n),
        .i_RX              (i_RX),
        .i_Frame_Indicator (i_Frame_Indicator),
        .ram               (ram_if),
        .o_Byte_Count      (byte_count),
        .o_Busy            (busy),
        .o_Frame_Done      (frame_done),
        .o_Frame_Error     (frame_error)
    );

    always #5 Clk = ~Clk;

    int compared = 0;
    int mismatched = 0;

    // Observed activity, sampled on the falling edge.
    logic [AW-1:0] obs_addr[$];
    logic [7:0]    obs_data[$];
    int            done_cnt;
    int            done_on_write;
    logic [AW-1:0] done_addr;
    int            err_cnt;

    always @(negedge Clk) begin
        if (i_Rst_n) begin
            if (ram_if.o_Enable_Write) begin
                obs_addr.push_back(ram_if.o_Write_Adress);
                obs_data.push_back(ram_if.o_RAM_Data);
            end
            if (frame_done) begin
                done_cnt++;
                if (ram_if.o_Enable_Write) begin
                    done_on_write++;
                    done_addr = ram_if.o_Write_Adress;
                end
            end
            if (frame_error) err_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clear_mon();
        @(posedge Clk);
        #1;
        obs_addr.delete();
        obs_data.delete();
        done_cnt = 0;
        done_on_write = 0;
        done_addr = '0;
        err_cnt = 0;
        @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        i_RX = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            i_RX = b[i];
            idle(CPB);
        end
        i_RX = stop_bit;
        idle(CPB);
        i_RX = 1'b1;
    endtask

    task automatic arm();
        i_Frame_Indicator = 1'b1;
        idle(4);
        i_Frame_Indicator = 1'b0;
        idle(6);
    endtask

    task automatic raise_indicator();
        i_Frame_Indicator = 1'b1;
        idle(6);
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        idle(3);
        compared++;
        if ({ram_if.o_Write_Adress, ram_if.o_RAM_Data, ram_if.o_Enable_Write,
             byte_count, busy, frame_done, frame_error} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: addr=%0h data=%0h we=%b cnt=%0d busy=%b done=%b err=%b, required all 0",
                     ram_if.o_Write_Adress, ram_if.o_RAM_Data, ram_if.o_Enable_Write,
                     byte_count, busy, frame_done, frame_error);
        end
        i_Rst_n = 1'b1;
        idle(5);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release_busy: got %b, required 0", busy);
        end
    endtask

    // Arm, send one full frame (fixed pattern or random bytes), check writes and completion.
    task automatic test_frame(input string tag, input bit fixed);
        logic [7:0] sent[$];
        logic [7:0] pattern [4];
        pattern = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        clear_mon();
        arm();
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_busy_armed: got %b, required 1", tag, busy);
        end
        for (int k = 0; k < BPF; k++) begin
            sent.push_back(fixed ? pattern[k] : 8'($urandom_range(0, 255)));
            send_byte(sent[k], 1'b1);
            idle($urandom_range(0, 20));
        end
        idle(2 * CPB);
        compared++;
        if (obs_data.size() != BPF) begin
            mismatched++;
            $display("FAIL %s_write_count: got %0d, required %0d", tag, obs_data.size(), BPF);
        end
        for (int k = 0; k < BPF && k < obs_data.size(); k++) begin
            compared++;
            if (obs_addr[k] !== AW'(k) || obs_data[k] !== sent[k]) begin
                mismatched++;
                $display("FAIL %s_write%0d: got addr=%0d data=%02h, required addr=%0d data=%02h",
                         tag, k, obs_addr[k], obs_data[k], k, sent[k]);
            end
        end
        compared++;
        if (done_cnt != 1 || done_on_write != 1 || done_addr !== AW'(BPF - 1)) begin
            mismatched++;
            $display("FAIL %s_done: got pulses=%0d with_write=%0d addr=%0d, required 1/1/%0d",
                     tag, done_cnt, done_on_write, done_addr, BPF - 1);
        end
        compared++;
        if (err_cnt != 0 || byte_count !== (AW + 1)'(BPF) || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_final: got err=%0d cnt=%0d busy=%b, required 0/%0d/0",
                     tag, err_cnt, byte_count, busy, BPF);
        end
        raise_indicator();
    endtask

    task automatic test_idle_bytes();
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b1);
            idle(4);
        end
        idle(2 * CPB);
        compared++;
        if (obs_data.size() != 0 || err_cnt != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_bytes: got writes=%0d err=%0d busy=%b, required 0/0/0",
                     obs_data.size(), err_cnt, busy);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] sent[$];
        int waited;
        clear_mon();
        arm();
        for (int k = 0; k < 2; k++) begin
            sent.push_back(8'($urandom_range(0, 255)));
            send_byte(sent[k], 1'b1);
        end
        waited = 0;
        while (err_cnt == 0 && waited < 3 * GAP) begin
            @(negedge Clk);
            #1;
            waited++;
        end
        idle(10);
        compared++;
        if (err_cnt != 1) begin
            mismatched++;
            $display("FAIL timeout_error_pulses: got %0d, required 1", err_cnt);
        end
        compared++;
        if (waited < GAP - CPB || waited > GAP + CPB) begin
            mismatched++;
            $display("FAIL timeout_latency: got %0d cycles, required about %0d", waited, GAP);
        end
        compared++;
        if (obs_data.size() != 2 || byte_count !== (AW + 1)'(2) || busy !== 1'b0 || done_cnt != 0) begin
            mismatched++;
            $display("FAIL timeout_state: got writes=%0d cnt=%0d busy=%b done=%0d, required 2/2/0/0",
                     obs_data.size(), byte_count, busy, done_cnt);
        end
        for (int k = 0; k < 2 && k < obs_data.size(); k++) begin
            compared++;
            if (obs_addr[k] !== AW'(k) || obs_data[k] !== sent[k]) begin
                mismatched++;
                $display("FAIL timeout_write%0d: got addr=%0d data=%02h, required addr=%0d data=%02h",
                         k, obs_addr[k], obs_data[k], k, sent[k]);
            end
        end
        raise_indicator();
    endtask

    task automatic test_stop_error();
        clear_mon();
        arm();
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        idle(2 * CPB);
        compared++;
        if (obs_data.size() != 0 || err_cnt != 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL stop_error: got writes=%0d err=%0d busy=%b, required 0/1/0",
                     obs_data.size(), err_cnt, busy);
        end
        idle(30 * CPB);
        raise_indicator();
        test_frame("after_stop_err", 1'b0);
    endtask

    task automatic test_glitch();
        clear_mon();
        arm();
        i_RX = 1'b0;
        idle(3);
        i_RX = 1'b1;
        idle(3 * CPB);
        compared++;
        if (obs_data.size() != 0 || err_cnt != 0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch: got writes=%0d err=%0d busy=%b, required 0/0/1",
                     obs_data.size(), err_cnt, busy);
        end
        raise_indicator();
    endtask

    task automatic test_short_frame();
        clear_mon();
        arm();
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle(5);
        i_Frame_Indicator = 1'b1;
        idle(10);
        compared++;
        if (err_cnt != 1 || obs_data.size() != 2 || busy !== 1'b0 || byte_count !== (AW + 1)'(2)) begin
            mismatched++;
            $display("FAIL short_frame: got err=%0d writes=%0d busy=%b cnt=%0d, required 1/2/0/2",
                     err_cnt, obs_data.size(), busy, byte_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        arm();
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        i_RX = 1'b0;
        idle(3 * CPB);
        compared++;
        if (obs_data.size() != 2 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset: got writes=%0d busy=%b, required 2/1", obs_data.size(), busy);
        end
        i_Rst_n = 1'b0;
        #1;
        compared++;
        if ({ram_if.o_Write_Adress, ram_if.o_RAM_Data, ram_if.o_Enable_Write,
             byte_count, busy, frame_done, frame_error} !== '0) begin
            mismatched++;
            $display("FAIL mid_frame_reset: addr=%0h data=%0h we=%b cnt=%0d busy=%b, required all 0",
                     ram_if.o_Write_Adress, ram_if.o_RAM_Data, ram_if.o_Enable_Write, byte_count, busy);
        end
        i_RX = 1'b1;
        i_Frame_Indicator = 1'b1;
        idle(5);
        i_Rst_n = 1'b1;
        idle(5);
        test_frame("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) test_frame($sformatf("b2b%0d", f), 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame("fixed_frame", 1'b1);
        test_idle_bytes();
        test_timeout();
        test_stop_error();
        test_glitch();
        test_short_frame();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
